// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor with ALU status flags.
// The carry chain is cut into STAGES equal slices; each pipeline stage adds
// one slice and forwards its carry, the partial sum and the remaining operand
// bits to the next stage. The final stage register drives all outputs.
// Valid/ready handshake: the whole pipe advances when the output slot is
// empty or being consumed, otherwise every stage holds.
// Legal parameter range: WIDTH >= 1, 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0.

module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SL = WIDTH / STAGES;

    // Per-stage registers: valid, slice carry, partial sum, operand bits
    // still to be added (b already conditionally inverted).
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    // Flags live alongside the final slice so they always match sum.
    logic              ovf_q;
    logic              zero_q;
    logic              neg_q;

    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_d;
    logic              zero_d;
    logic              neg_d;

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  a_src;
    logic [WIDTH-1:0]  b_src;
    logic [WIDTH-1:0]  s_src;
    logic              c_src;
    logic              v_src;
    logic [SL:0]       slc;
    logic              top_c;
    int                prev;

    assign adv       = !v_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign b_eff     = b ^ {WIDTH{sub}};

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

    // Next value of every stage: add this stage's slice to the previous stage's state.
    always_comb begin
        v_d   = '0;
        c_d   = '0;
        top_c = 1'b0;
        a_src = '0;
        b_src = '0;
        s_src = '0;
        c_src = 1'b0;
        v_src = 1'b0;
        slc   = '0;
        prev  = 0;
        for (int k = 0; k < STAGES; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                a_src = a;
                b_src = b_eff;
                s_src = '0;
                c_src = sub;
                v_src = in_valid;
            end else begin
                a_src = a_q[prev];
                b_src = b_q[prev];
                s_src = s_q[prev];
                c_src = c_q[prev];
                v_src = v_q[prev];
            end
            slc = {1'b0, a_src[k*SL +: SL]} + {1'b0, b_src[k*SL +: SL]} + {{SL{1'b0}}, c_src};
            s_d[k]             = s_src;
            s_d[k][k*SL +: SL] = slc[SL-1:0];
            c_d[k]             = slc[SL];
            v_d[k]             = v_src;
            a_d[k]             = a_src;
            b_d[k]             = b_src;
            // Carry into the MSB recovered from the MSB's sum bit: s = a ^ b ^ cin.
            if (k == STAGES - 1) begin
                top_c = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ slc[SL-1];
            end
        end
        ovf_d  = top_c ^ c_d[STAGES-1];
        zero_d = (s_d[STAGES-1] == '0);
        neg_d  = s_d[STAGES-1][WIDTH-1];
    end

    // Pipeline registers: shift all stages together on adv, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three instances (32/4, 8/1, 8/8) sharing clock
// and reset. A scoreboard checks the 32-bit instance against an arithmetic
// model on every output transfer; directed vectors pin literal results.

module tb_pipelined_add_sub;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v32, r32, ov32, or32, sub32, c32, o32, z32, n32;
    logic [31:0] a32, b32, s32;
    logic        v1, r1, ov1, or1, sub1, c1, o1, z1, n1;
    logic [7:0]  a1, b1, s1;
    logic        v8, r8, ov8, or8, sub8, c8, o8, z8, n8;
    logic [7:0]  a8, b8, s8;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
        .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(c32),
        .ovf(o32), .zero(z32), .neg(n32));

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
        .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(c1),
        .ovf(o1), .zero(z1), .neg(n1));

    pipelined_add_sub #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(c8),
        .ovf(o8), .zero(z8), .neg(n8));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        res_t   r;
        longint one, mask, half, ua, ub, sa, sb, raw, sr;
        one  = 1;
        mask = (one << w) - 1;
        half = one << (w - 1);
        ua   = longint'({32'd0, a}) & mask;
        ub   = longint'({32'd0, b}) & mask;
        sa   = (ua >= half) ? ua - (one << w) : ua;
        sb   = (ub >= half) ? ub - (one << w) : ub;
        raw  = s ? ua - ub : ua + ub;
        sr   = s ? sa - sb : sa + sb;
        r.sum = 32'(raw & mask);
        r.c   = s ? (ua >= ub) : (raw > mask);
        r.o   = (sr < -half) || (sr >= half);
        r.z   = ((raw & mask) == 0);
        r.n   = ((raw & mask) >= half);
        return r;
    endfunction

    // Scoreboard for the 32-bit instance.
    res_t        exp_q[$];
    logic [31:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [35:0] prev_out   = '0;

    always @(negedge rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
    end

    // Compare process: handshake rules, hold-while-stalled, and in-order results.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", r32, (!ov32 || or32));
            if (prev_stall) check("hold_outputs", {s32, c32, o32, z32, n32}, prev_out);
            if (v32 && r32) exp_q.push_back(model(32, a32, b32, sub32));
            if (ov32 && or32) begin : pop
                res_t e;
                got_q.push_back(s32);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got sum %0h, expected no beat", s32);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum",  s32, e.sum);
                    check("sb_cout", c32, e.c);
                    check("sb_ovf",  o32, e.o);
                    check("sb_zero", z32, e.z);
                    check("sb_neg",  n32, e.n);
                end
            end
            prev_stall = ov32 && !or32;
            prev_out   = {s32, c32, o32, z32, n32};
        end
    end

    task automatic push32(input logic [31:0] a, input logic [31:0] b, input logic s);
        int g;
        g = 0;
        a32 = a; b32 = b; sub32 = s; v32 = 1'b1;
        #1;
        while (!r32 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("push32_ready", g < 50, 1);
        @(posedge clk); #1;
        v32 = 1'b0;
    endtask

    task automatic lit32(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] es, input logic ec,
                         input logic eo, input logic ez, input logic en);
        int lat;
        push32(a, b, s);
        lat = 0;
        while (!ov32 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({nm, "_latency"}, lat, 3);
        check({nm, "_sum"},  s32, es);
        check({nm, "_cout"}, c32, ec);
        check({nm, "_ovf"},  o32, eo);
        check({nm, "_zero"}, z32, ez);
        check({nm, "_neg"},  n32, en);
        @(posedge clk); #1;
    endtask

    task automatic run8(input bit deep, input logic [7:0] a, input logic [7:0] b,
                        input logic s, output int lat, output res_t r);
        @(posedge clk); #1;
        if (deep) begin a8 = a; b8 = b; sub8 = s; v8 = 1'b1; end
        else      begin a1 = a; b1 = b; sub1 = s; v1 = 1'b1; end
        @(posedge clk); #1;
        v8 = 1'b0; v1 = 1'b0;
        lat = 1;
        while (!(deep ? ov8 : ov1) && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        r.sum = deep ? {24'd0, s8} : {24'd0, s1};
        r.c   = deep ? c8 : c1;
        r.o   = deep ? o8 : o1;
        r.z   = deep ? z8 : z1;
        r.n   = deep ? n8 : n1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   i, cyc, stalls, lat;
        logic acc;
        res_t r, m;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vs [4];

        rst_n = 1'b0;
        v32 = 0; or32 = 1; a32 = 0; b32 = 0; sub32 = 0;
        v1 = 0;  or1 = 1;  a1 = 0;  b1 = 0;  sub1 = 0;
        v8 = 0;  or8 = 1;  a8 = 0;  b8 = 0;  sub8 = 0;

        // Pin the model to hand-computed results.
        m = model(32, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("model_wrap_sum", m.sum, 0);
        check("model_wrap_cout", m.c, 1);
        m = model(32, 32'h8000_0000, 32'd1, 1'b1);
        check("model_subovf_sum", m.sum, 32'h7FFF_FFFF);
        check("model_subovf_ovf", m.o, 1);
        m = model(8, 32'h80, 32'h01, 1'b1);
        check("model8_sum", m.sum, 32'h7F);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ov32, 0);
        check("rst_in_ready", r32, 1);
        check("rst_sum", s32, 0);
        check("rst_flags", {c32, o32, z32, n32}, 0);
        check("rst_out_valid_s1", ov1, 0);
        check("rst_out_valid_s8", ov8, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        lit32("wrap",   32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
        lit32("sub57",  32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 0, 0, 0, 1);
        lit32("addovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
        lit32("subovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1, 1, 0, 0);

        // Back-to-back stream with a 3-cycle output stall in the middle.
        got_q.delete();
        i = 0; cyc = 0; stalls = 0;
        while (i < 6 && cyc < 60) begin
            a32 = 32'(i); b32 = 32'(10 * i); sub32 = 1'b0; v32 = 1'b1;
            or32 = !(cyc >= 4 && cyc < 7);
            #1;
            acc = r32;
            if (!acc) stalls++;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        v32 = 1'b0; or32 = 1'b1;
        check("stream_stall_cycles", stalls, 3);
        repeat (10) @(posedge clk);
        #1;
        check("stream_count", got_q.size(), 6);
        for (int j = 0; j < 6 && j < got_q.size(); j++) check("stream_order", got_q[j], 11 * j);

        // Reset with three beats in flight: none may ever emerge.
        got_q.delete();
        for (int j = 0; j < 3; j++) begin
            a32 = 32'(100 + j); b32 = 32'd1; sub32 = 1'b0; v32 = 1'b1;
            @(posedge clk); #1;
        end
        v32 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", ov32, 0);
        check("midrst_sum", s32, 0);
        check("midrst_flags", {c32, o32, z32, n32}, 0);
        check("midrst_in_ready", r32, 1);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_beats", got_q.size(), 0);

        lit32("zero_sub", 32'd0, 32'd0, 1'b1, 32'd0, 1, 0, 1, 0);

        // Single-stage and one-bit-slice instances.
        run8(1'b0, 8'h80, 8'h01, 1'b1, lat, r);
        check("s1_latency", lat, 1);
        check("s1_sum", r.sum, 32'h7F);
        check("s1_ovf", r.o, 1);
        check("s1_cout", r.c, 1);
        run8(1'b1, 8'hFF, 8'hFF, 1'b0, lat, r);
        check("s8_latency", lat, 8);
        check("s8_sum", r.sum, 32'hFE);
        check("s8_cout", r.c, 1);
        check("s8_neg", r.n, 1);
        check("s8_ovf", r.o, 0);

        va[0] = 8'h00; vb[0] = 8'h00; vs[0] = 1'b0;
        va[1] = 8'h7F; vb[1] = 8'h01; vs[1] = 1'b0;
        va[2] = 8'h01; vb[2] = 8'h02; vs[2] = 1'b1;
        va[3] = 8'h80; vb[3] = 8'h80; vs[3] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            m = model(8, {24'd0, va[j]}, {24'd0, vb[j]}, vs[j]);
            run8(1'b0, va[j], vb[j], vs[j], lat, r);
            check("s1_vec", {r.sum, r.c, r.o, r.z, r.n}, {m.sum, m.c, m.o, m.z, m.n});
            run8(1'b1, va[j], vb[j], vs[j], lat, r);
            check("s8_vec", {r.sum, r.c, r.o, r.z, r.n}, {m.sum, m.c, m.o, m.z, m.n});
        end

        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
